// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: FSM states,
// instruction fields, ALU operations and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type Funct field to ALU operation; flags unsupported Funct codes so the
// controller can abort the instruction before write-back.
module alu_op_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 legal
);

  logic [2:0] op;

  always_comb begin
    op    = ALU_AND;
    legal = 1'b1;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

  // Wider ALU control buses carry the 3-bit code with upper bits zeroed.
  always_comb begin
    alu_ctrl      = '0;
    alu_ctrl[2:0] = op;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle controller: sequences fetch/decode/execute/memory/
// write-back and drives all datapath enables and selects.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTRL_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ULASrcA,
  output logic [1:0]           ULASrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalOp,
  output logic [3:0]           State
);

  state_t                 state;
  state_t                 next_state;
  logic                   mem_done;
  logic [ALUCTRL_W-1:0]   funct_ctrl;
  logic                   funct_legal;
  logic [2:0]             alu_op;
  logic                   unused_zero;

  // Zero only gates the PC load inside the datapath (Branch & Zero).
  assign unused_zero = Zero;

  assign mem_done = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  alu_op_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_op_decoder (
    .funct    (Funct),
    .alu_ctrl (funct_ctrl),
    .legal    (funct_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ULASrcA    = 1'b0;
    ULASrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    IllegalOp  = 1'b0;
    alu_op     = ALU_AND;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ULASrcB = SRCB_FOUR;
        alu_op  = ALU_ADD;
        if (mem_done) begin
          PCWrite    = 1'b1;
          IRWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ULASrcB = SRCB_IMM;
        alu_op  = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BEQ;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            IllegalOp  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_IMM;
        alu_op     = ALU_ADD;
        next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_done) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_done) next_state = S_FETCH;
      end
      S_EXECUTE: begin
        ULASrcA = 1'b1;
        ULASrcB = SRCB_B;
        if (funct_legal) begin
          next_state = S_ALUWB;
        end else begin
          IllegalOp  = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_B;
        alu_op     = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        ULASrcA    = 1'b1;
        ULASrcB    = SRCB_IMM;
        alu_op     = ALU_ADD;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_JUMP;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Holding reset must never let a stale state commit architectural writes.
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      Branch    = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  always_comb begin
    ALUControl = '0;
    if (state == S_EXECUTE) ALUControl = funct_ctrl;
    else                    ALUControl[2:0] = alu_op;
  end

  assign State = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: one controller without memory handshake, one with it.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst_n, zero, memready;
  logic [5:0] opcode, funct;
  logic       pcwrite, branch, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, srca, illegal;
  logic [1:0] srcb, pcsrc;
  logic [2:0] aluctl;
  logic [3:0] state;

  logic       rst1_n, zero1, memready1;
  logic [5:0] opcode1, funct1;
  logic       pcwrite1, branch1, iord1, memread1, memwrite1, irwrite1;
  logic       memtoreg1, regdst1, regwrite1, srca1, illegal1;
  logic [1:0] srcb1, pcsrc1;
  logic [2:0] aluctl1;
  logic [3:0] state1;

  multicycle_controller #(.MEM_HANDSHAKE(0), .ALUCTRL_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .MemReady(memready), .PCWrite(pcwrite), .Branch(branch), .IorD(iord),
    .MemRead(memread), .MemWrite(memwrite), .IRWrite(irwrite),
    .MemtoReg(memtoreg), .RegDst(regdst), .RegWrite(regwrite),
    .ULASrcA(srca), .ULASrcB(srcb), .PCSrc(pcsrc), .ALUControl(aluctl),
    .IllegalOp(illegal), .State(state)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1), .ALUCTRL_W(3)) dut1 (
    .clk(clk), .rst_n(rst1_n), .Opcode(opcode1), .Funct(funct1), .Zero(zero1),
    .MemReady(memready1), .PCWrite(pcwrite1), .Branch(branch1), .IorD(iord1),
    .MemRead(memread1), .MemWrite(memwrite1), .IRWrite(irwrite1),
    .MemtoReg(memtoreg1), .RegDst(regdst1), .RegWrite(regwrite1),
    .ULASrcA(srca1), .ULASrcB(srcb1), .PCSrc(pcsrc1), .ALUControl(aluctl1),
    .IllegalOp(illegal1), .State(state1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; memready = 1'b0; opcode = 6'b0; funct = 6'b0;
    rst1_n = 1'b0; zero1 = 1'b0; memready1 = 1'b0; opcode1 = 6'b101011; funct1 = 6'b0;
    tick(); tick();

    // Reset: held-FETCH outputs but no write enables
    chk("rst_state", state, 4'd0);
    chk("rst_pcwrite", pcwrite, 1'b0);
    chk("rst_irwrite", irwrite, 1'b0);
    chk("rst_regwrite", regwrite, 1'b0);
    rst_n = 1'b1; rst1_n = 1'b1; #1;
    chk("first_fetch_state", state, 4'd0);
    chk("fetch_pcwrite", pcwrite, 1'b1);
    chk("fetch_irwrite", irwrite, 1'b1);
    chk("fetch_memread", memread, 1'b1);
    chk("fetch_srcb", srcb, 2'b01);
    chk("fetch_alu", aluctl, 3'b010);

    // lw
    opcode = 6'b100011;
    tick(); chk("lw_s1", state, 4'd1); chk("lw_dec_srcb", srcb, 2'b10);
    chk("lw_dec_regwrite", regwrite, 1'b0);
    tick(); chk("lw_s2", state, 4'd2); chk("lw_adr_srca", srca, 1'b1);
    tick(); chk("lw_s3", state, 4'd3); chk("lw_rd_iord", iord, 1'b1);
    chk("lw_rd_memread", memread, 1'b1); chk("lw_rd_regwrite", regwrite, 1'b0);
    chk("lw_rd_memtoreg", memtoreg, 1'b0);
    tick(); chk("lw_s4", state, 4'd4); chk("lw_wb_regwrite", regwrite, 1'b1);
    chk("lw_wb_memtoreg", memtoreg, 1'b1);
    tick(); chk("lw_done", state, 4'd0); chk("lw_done_regwrite", regwrite, 1'b0);

    // R-type sub
    opcode = 6'b000000; funct = 6'b100010;
    tick(); chk("sub_s1", state, 4'd1);
    tick(); chk("sub_s6", state, 4'd6); chk("sub_alu", aluctl, 3'b110);
    chk("sub_srca", srca, 1'b1); chk("sub_srcb", srcb, 2'b00);
    chk("sub_ex_regwrite", regwrite, 1'b0);
    tick(); chk("sub_s7", state, 4'd7); chk("sub_regdst", regdst, 1'b1);
    chk("sub_regwrite", regwrite, 1'b1);
    tick(); chk("sub_done", state, 4'd0);

    // beq, Zero = 1 then Zero = 0
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; zero = z[0];
      tick(); chk("beq_s1", state, 4'd1);
      tick(); chk("beq_s8", state, 4'd8); chk("beq_branch", branch, 1'b1);
      chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_alu", aluctl, 3'b110);
      chk("beq_pcwrite", pcwrite, 1'b0);
      tick(); chk("beq_done", state, 4'd0);
    end

    // sw without handshake: 4 cycles
    opcode = 6'b101011;
    tick(); chk("sw_s1", state, 4'd1);
    tick(); chk("sw_s2", state, 4'd2);
    tick(); chk("sw_s5", state, 4'd5); chk("sw_memwrite", memwrite, 1'b1);
    chk("sw_iord", iord, 1'b1);
    tick(); chk("sw_done", state, 4'd0); chk("sw_done_memwrite", memwrite, 1'b0);

    // addi
    opcode = 6'b001000;
    tick(); chk("addi_s1", state, 4'd1);
    tick(); chk("addi_s9", state, 4'd9); chk("addi_alu", aluctl, 3'b010);
    chk("addi_srcb", srcb, 2'b10); chk("addi_srca", srca, 1'b1);
    tick(); chk("addi_s10", state, 4'd10); chk("addi_regwrite", regwrite, 1'b1);
    chk("addi_regdst", regdst, 1'b0);
    tick(); chk("addi_done", state, 4'd0);

    // j
    opcode = 6'b000010;
    tick(); chk("j_s1", state, 4'd1);
    tick(); chk("j_s11", state, 4'd11); chk("j_pcwrite", pcwrite, 1'b1);
    chk("j_pcsrc", pcsrc, 2'b10);
    tick(); chk("j_done", state, 4'd0);

    // Illegal opcode
    opcode = 6'b111111;
    tick(); chk("ilop_s1", state, 4'd1); chk("ilop_pulse", illegal, 1'b1);
    chk("ilop_regwrite", regwrite, 1'b0); chk("ilop_memwrite", memwrite, 1'b0);
    tick(); chk("ilop_next", state, 4'd0); chk("ilop_clear", illegal, 1'b0);

    // Illegal Funct
    opcode = 6'b000000; funct = 6'b000111;
    tick(); chk("ilfn_s1", state, 4'd1); chk("ilfn_dec_quiet", illegal, 1'b0);
    tick(); chk("ilfn_s6", state, 4'd6); chk("ilfn_pulse", illegal, 1'b1);
    chk("ilfn_regwrite", regwrite, 1'b0); chk("ilfn_memwrite", memwrite, 1'b0);
    tick(); chk("ilfn_next", state, 4'd0); chk("ilfn_clear", illegal, 1'b0);
    chk("ilfn_no_wb", regwrite, 1'b0);

    // Reset while in MEMRD
    opcode = 6'b100011;
    tick(); tick(); tick(); chk("rmid_s3", state, 4'd3);
    rst_n = 1'b0; #1;
    chk("rmid_state", state, 4'd0); chk("rmid_pcwrite", pcwrite, 1'b0);
    chk("rmid_irwrite", irwrite, 1'b0); chk("rmid_memwrite", memwrite, 1'b0);
    chk("rmid_regwrite", regwrite, 1'b0); chk("rmid_branch", branch, 1'b0);
    tick(); chk("rmid_after_edge", state, 4'd0);
    rst_n = 1'b1; #1;
    chk("rmid_resume_state", state, 4'd0); chk("rmid_resume_pcwrite", pcwrite, 1'b1);
    tick(); chk("rmid_resume_decode", state, 4'd1);

    // Handshake controller: FETCH waits for MemReady, sw stalls in MEMWR
    chk("hs_fetch_state", state1, 4'd0);
    chk("hs_fetch_wait_pcwrite", pcwrite1, 1'b0);
    chk("hs_fetch_wait_irwrite", irwrite1, 1'b0);
    memready1 = 1'b1; #1;
    chk("hs_fetch_ready_pcwrite", pcwrite1, 1'b1);
    tick(); chk("hs_s1", state1, 4'd1);
    memready1 = 1'b0;
    tick(); chk("hs_s2", state1, 4'd2);
    for (int c = 1; c <= 3; c++) begin
      tick(); chk("hs_memwr_wait_state", state1, 4'd5);
      chk("hs_memwr_wait_memwrite", memwrite1, 1'b1);
    end
    memready1 = 1'b1; #1;
    chk("hs_memwr_last_state", state1, 4'd5);
    chk("hs_memwr_last_memwrite", memwrite1, 1'b1);
    tick(); chk("hs_done", state1, 4'd0); chk("hs_done_memwrite", memwrite1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait on MemReady; 0 = MemReady is ignored and memory completes in one cycle.
REQ-002 The block SHALL have parameter ALUCTRL_W, default 3, meaning: width of ALUControl; values ≥3, upper bits zero-filled.

Ports (name, direction, width, meaning):
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
REQ-004 Instruction and memory inputs:
- Opcode  in  6  instruction [31:26], valid from DECODE onward.
- Funct  in  6  instruction [5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access complete.
REQ-005 Datapath enables:
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load if Zero.
- IorD  out  1  memory address from ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
REQ-006 Datapath selects:
- MemtoReg  out  1  write-back data from MDR.
- RegDst  out  1  write-back register is rd.
- RegWrite  out  1  register file write.
- ULASrcA  out  1  ALU A = register A (0 = PC).
- ULASrcB  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm.
- PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUControl  out  ALUCTRL_W  ALU operation.
REQ-007 Status outputs:
- IllegalOp  out  1  one-cycle pulse on an undecodable instruction.
- State  out  4  current state, for debug.

Function
REQ-008 The FSM SHALL use these states and encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- EXECUTE = 6, ALUWB = 7, BEQ = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
REQ-009 FETCH SHALL assert MemRead, ULASrcB = 01, ALUControl = add.
- PCWrite and IRWrite assert only in the cycle the read completes (MemReady = 1, or always when MEM_HANDSHAKE = 0).
- Next state: DECODE on completion, otherwise stay in FETCH.
REQ-010 DECODE SHALL assert ULASrcB = 10, ALUControl = add, then branch on Opcode:
- 100011 (lw) or 101011 (sw) → MEMADR
- 000000 (R-type) → EXECUTE
- 000100 (beq) → BEQ
- 001000 (addi) → ADDIEX
- 000010 (j) → JUMP
- any other opcode → FETCH, with IllegalOp = 1 for that cycle.
REQ-011 MEMADR SHALL assert ULASrcA = 1, ULASrcB = 10, add; next state MEMRD for lw, MEMWR for sw.
REQ-012 MEMRD SHALL assert IorD and MemRead, and stay until completion, then go to MEMWB.
- MEMWR asserts IorD and MemWrite, and stays until completion, then goes to FETCH.
- MemWrite SHALL remain asserted for every cycle spent in MEMWR.
REQ-013 MEMWB SHALL assert RegWrite and MemtoReg, then go to FETCH.
REQ-014 EXECUTE SHALL assert ULASrcA = 1, ULASrcB = 00, with ALUControl from Funct:
- 100000 → 010 (add)
- 100010 → 110 (sub)
- 100100 → 000 (and)
- 100101 → 001 (or)
- 101010 → 111 (slt)
- any other Funct → go to FETCH with IllegalOp = 1; no write-back occurs.
REQ-015 ALUWB SHALL assert RegDst and RegWrite, then go to FETCH.
REQ-016 BEQ SHALL assert ULASrcA = 1, ULASrcB = 00, sub, Branch = 1, PCSrc = 01, then go to FETCH.
REQ-017 ADDIEX SHALL compute A + SignImm, then go to ADDIWB.
- ADDIWB asserts RegWrite with RegDst = 0, then goes to FETCH.
REQ-018 JUMP SHALL assert PCWrite with PCSrc = 10, then go to FETCH.
REQ-019 All outputs SHALL be a combinational (Moore) function of State, plus Opcode/Funct/MemReady where stated; unlisted outputs are 0.
REQ-020 Instruction latency (MEM_HANDSHAKE = 0): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- With handshake, each memory state adds its wait cycles.

Reset
REQ-021 When rst_n = 0 at a rising clk edge, the state SHALL become FETCH regardless of current state, including mid-MEMWR or mid-wait.
REQ-022 While in reset, every write enable (PCWrite, IRWrite, MemWrite, RegWrite, Branch) SHALL be forced to 0.
- IllegalOp = 0 and State = 0 during reset.
REQ-023 The first non-reset cycle SHALL be FETCH.

Structure
REQ-024 A shared package SHALL hold:
- the state enumeration;
- opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
- Funct constants;
- ALU operation codes;
- ULASrcB / PCSrc encodings.
REQ-025 The Funct-to-ALUControl mapping SHALL be one sub-module, alu_op_decoder, combinational, parameterised by ALUCTRL_W.
- The FSM core stays in the top module.

Verification
REQ-026 The bench SHALL cover these directed scenarios (MEM_HANDSHAKE = 0 unless stated):
- lw (Opcode 100011): States 0,1,2,3,4; RegWrite = 1 and MemtoReg = 1 only in state 4; back to 0 after 5 cycles.
- R-type sub (Funct 100010): EXECUTE shows ALUControl = 110; ALUWB shows RegDst = 1, RegWrite = 1; then FETCH.
- beq with Zero = 1: BEQ shows Branch = 1, PCSrc = 01, ALUControl = 110. Repeat with Zero = 0: same outputs, PCWrite = 0.
- Opcode 111111, then Funct 000111: IllegalOp pulses for exactly 1 cycle, next State = 0, RegWrite and MemWrite never asserted.
- MEM_HANDSHAKE = 1, sw with MemReady low for 3 cycles: MEMWR held 4 cycles with MemWrite = 1 throughout; FETCH follows the MemReady = 1 cycle.
- rst_n = 0 for 1 cycle while in MEMRD: next State = 0, all write enables 0 during reset, normal fetch resumes.
